// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce/edge-detect input conditioning stage.
package debounce_pkg;

  typedef enum logic {ST_STABLE, ST_QUALIFY} deb_state_t;

  // Counter width large enough to hold values 0..n-1; never less than one bit.
  function automatic int unsigned calc_cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_chain #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_edge_sync.sv
// Synchronizes a raw level, rejects glitches shorter than DEBOUNCE_CYCLES and
// emits a clean level plus one-cycle rise/fall pulses.
module debounce_edge_sync
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int unsigned     CNT_W    = calc_cnt_w(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s;
  deb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (din),
    .q    (s)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Qualification FSM; pulses are asserted on the same edge that updates q.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_STABLE: begin
        cnt_d = '0;
        if (s != q_q) begin
          // A one-cycle window accepts immediately without visiting QUALIFY.
          if (DEBOUNCE_CYCLES == 1) begin
            q_d    = s;
            rise_d = s;
            fall_d = !s;
          end else begin
            state_d = ST_QUALIFY;
            cnt_d   = CNT_ONE;
          end
        end
      end
      ST_QUALIFY: begin
        if (s == q_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
          q_d     = s;
          rise_d  = s;
          fall_d  = !s;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  assign q    = q_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = (state_q == ST_QUALIFY);

endmodule

// File: tb/tb_debounce_edge_sync.sv
// Scoreboard bench for debounce_edge_sync: directed scenarios plus a random phase
// whose expected pulses come from a run-length reference model.
module tb_debounce_edge_sync;

  localparam int unsigned SS  = 2;
  localparam int unsigned DC  = 16;
  localparam int unsigned LAT = SS + DC;

  typedef struct {
    int unsigned at_edge;
    logic        is_rise;
  } exp_t;

  logic clk;
  logic reset;
  logic din;
  logic q, rise, fall, busy;

  int          checks;
  int          errors;
  int unsigned edge_n;
  exp_t        exp_q[$];

  logic        model_en;
  logic        m_s0, m_s1, m_q;
  int          m_run;
  int          trans_cnt, pulse_cnt;
  logic        q_prev;

  debounce_edge_sync #(
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .din  (din),
    .q    (q),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Called right after driving a new din level at a negedge: the next edge
  // samples it, and q/pulse update LAT edges later counting that edge as one.
  task automatic expect_pulse(input logic is_rise);
    exp_t e;
    e.at_edge = edge_n + LAT;
    e.is_rise = is_rise;
    exp_q.push_back(e);
  endtask

  task automatic run_count(input int n, output int busy_hi);
    busy_hi = 0;
    repeat (n) begin
      @(negedge clk);
      if (busy === 1'b1) busy_hi++;
    end
  endtask

  // Reference model: q flips once s has differed from it on DC consecutive edges.
  initial begin
    m_s0 = 1'b0; m_s1 = 1'b0; m_q = 1'b0; m_run = 0;
    forever begin
      @(posedge clk);
      if (model_en) begin
        if (!reset) begin
          m_s0 = 1'b0; m_s1 = 1'b0; m_q = 1'b0; m_run = 0;
        end else begin
          if (m_s1 != m_q) begin
            m_run++;
            if (m_run == DC) begin
              exp_t e;
              m_q       = m_s1;
              m_run     = 0;
              e.at_edge = edge_n + 1;
              e.is_rise = m_q;
              exp_q.push_back(e);
            end
          end else begin
            m_run = 0;
          end
          m_s1 = m_s0;
          m_s0 = din;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a pulse.
  initial begin
    q_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      checks++;
      if (rise === 1'b1 && fall === 1'b1) begin
        errors++;
        $display("FAIL rise_fall_both: rise=%b fall=%b expected not both (edge %0d)", rise, fall, edge_n);
      end
      if (reset === 1'b1) begin
        checks++;
        if ((q !== q_prev) != (rise === 1'b1 || fall === 1'b1)) begin
          errors++;
          $display("FAIL pulse_vs_q: q %b->%b rise=%b fall=%b (edge %0d)", q_prev, q, rise, fall, edge_n);
        end
      end
      if (rise === 1'b1 || fall === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: rise=%b fall=%b none expected (edge %0d)", rise, fall, edge_n);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.at_edge != edge_n || e.is_rise !== rise || q !== rise) begin
            errors++;
            $display("FAIL pulse: edge %0d rise=%b q=%b expected edge %0d rise=%b q=%b",
                     edge_n, rise, q, e.at_edge, e.is_rise, e.is_rise);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].at_edge <= edge_n) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_pulse: no pulse at edge %0d expected rise=%b at edge %0d", edge_n, e.is_rise, e.at_edge);
      end
      if (model_en && reset === 1'b1) begin
        checks++;
        if (q !== m_q) begin
          errors++;
          $display("FAIL model_q: got %b expected %b (edge %0d)", q, m_q, edge_n);
        end
        if (q !== q_prev) trans_cnt++;
        if (rise === 1'b1 || fall === 1'b1) pulse_cnt++;
      end
      q_prev = q;
    end
  end

  initial begin
    int b1, b2, total, len;
    checks = 0; errors = 0; model_en = 1'b0;
    trans_cnt = 0; pulse_cnt = 0;
    reset = 1'b0;
    din   = 1'b1;

    // Reset with din high, then release: rise expected LAT edges later.
    repeat (3) begin
      @(negedge clk);
      check_bit("rst_q", q, 1'b0);
      check_bit("rst_rise", rise, 1'b0);
      check_bit("rst_busy", busy, 1'b0);
    end
    reset = 1'b1;
    expect_pulse(1'b1);
    run_count(25, b1);
    check_int("t1_busy_cycles", b1, DC - 1);
    check_bit("t1_q", q, 1'b1);

    // Short low glitch while q=1: no pulse, qualification abandoned.
    din = 1'b0;
    run_count(10, b1);
    din = 1'b1;
    run_count(15, b2);
    check_int("glitch_busy_cycles", b1 + b2, 10);
    check_bit("glitch_q", q, 1'b1);
    check_int("glitch_cnt", int'(dut.cnt_q), 0);

    // Low for DC-1 synchronized cycles, reverting on the accepting edge: no fall.
    din = 1'b0;
    run_count(15, b1);
    din = 1'b1;
    run_count(20, b2);
    check_int("edge15_busy_cycles", b1 + b2, DC - 1);
    check_bit("edge15_q", q, 1'b1);
    check_bit("edge15_busy", busy, 1'b0);

    // Held low: fall exactly once.
    din = 1'b0;
    expect_pulse(1'b0);
    run_count(25, b1);
    check_int("fall_busy_cycles", b1, DC - 1);
    check_bit("fall_q", q, 1'b0);

    // From q=0, din high for 30 cycles: single rise.
    din = 1'b1;
    expect_pulse(1'b1);
    run_count(30, b1);
    check_int("rise_busy_cycles", b1, DC - 1);
    check_bit("rise_q", q, 1'b1);

    // Reset during qualification at count 9: aborted, no pulse.
    din = 1'b0;
    repeat (11) @(negedge clk);
    check_int("mid_cnt", int'(dut.cnt_q), 9);
    check_bit("mid_busy", busy, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check_bit("abort_q", q, 1'b0);
    check_bit("abort_busy", busy, 1'b0);
    check_int("abort_cnt", int'(dut.cnt_q), 0);
    check_bit("abort_rise", rise, 1'b0);
    check_bit("abort_fall", fall, 1'b0);

    // Random toggling checked against the reference model.
    model_en = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    total = 0;
    while (total < 10000) begin
      din = ~din;
      len = int'($urandom_range(1, 40));
      repeat (len) @(negedge clk);
      total += len;
    end
    repeat (LAT + 5) @(negedge clk);
    check_int("queue_drained", exp_q.size(), 0);
    check_int("pulses_eq_transitions", pulse_cnt, trans_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
